// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of a single-outstanding memory port.
// Optional feature: define MEM_ARB_RR_EN for round-robin contention; default is data-port priority.
module mem_arbiter #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_ack,
   output logic        if_err,
   output logic [31:0] if_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_ack,
   output logic        d_err,
   output logic [31:0] d_rdata,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_data_in,
   output logic        mem_load_store,
   output logic [1:0]  mem_op,
   input  logic [31:0] mem_data_out,
   input  logic        mem_done,
   output logic        busy,
   output logic        owner_d
);

   localparam int unsigned     CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   state_t           state_q,    state_d;
   logic             grant_d_q,  grant_d_d;   // 1 = current/last grant is the data port
   logic [31:0]      addr_q,     addr_d;
   logic [31:0]      wdata_q,    wdata_d;
   logic             we_q,       we_d;
   logic [CNT_W-1:0] cnt_q,      cnt_d;
   logic             err_q,      err_d;
   logic [31:0]      if_rdata_q, if_rdata_d;
   logic [31:0]      d_rdata_q,  d_rdata_d;

   logic             pick_d;
   logic             any_req;

   assign any_req = if_req | d_req;

`ifdef MEM_ARB_RR_EN
   // Under contention the port that did not win last time gets the grant.
   assign pick_d = d_req & (~if_req | ~grant_d_q);
`else
   assign pick_d = d_req;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         grant_d_q  <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         we_q       <= 1'b0;
         cnt_q      <= '0;
         err_q      <= 1'b0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
      end else begin
         state_q    <= state_d;
         grant_d_q  <= grant_d_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         we_q       <= we_d;
         cnt_q      <= cnt_d;
         err_q      <= err_d;
         if_rdata_q <= if_rdata_d;
         d_rdata_q  <= d_rdata_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      grant_d_d  = grant_d_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      we_d       = we_q;
      cnt_d      = cnt_q;
      err_d      = err_q;
      if_rdata_d = if_rdata_q;
      d_rdata_d  = d_rdata_q;

      case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               grant_d_d = pick_d;
               addr_d    = pick_d ? d_addr : if_addr;
               wdata_d   = pick_d ? d_wdata : 32'h0;
               we_d      = pick_d & d_we;
               err_d     = 1'b0;
               state_d   = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            cnt_d   = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            // A completion in the same cycle as the timeout still counts as success.
            if (mem_done) begin
               if (grant_d_q) begin
                  d_rdata_d = mem_data_out;
               end else begin
                  if_rdata_d = mem_data_out;
               end
               err_d   = 1'b0;
               state_d = ST_RESP;
            end else if (cnt_q == CNT_LAST) begin
               err_d   = 1'b1;
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign if_ack         = (state_q == ST_RESP) & ~grant_d_q;
   assign d_ack          = (state_q == ST_RESP) &  grant_d_q;
   assign if_err         = if_ack & err_q;
   assign d_err          = d_ack  & err_q;
   assign if_rdata       = if_rdata_q;
   assign d_rdata        = d_rdata_q;
   assign mem_load_store = (state_q == ST_ISSUE);
   assign mem_addr       = addr_q;
   assign mem_data_in    = wdata_q;
   assign mem_op         = {1'b0, we_q};
   assign busy           = (state_q != ST_IDLE);
   assign owner_d        = grant_d_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed + randomized bench for mem_arbiter with a latency-programmable memory responder
// and a transaction-level reference model (grant policy, ack latency, error, read data).
module tb_mem_arbiter;

   localparam int T       = 16;
   localparam int NO_RESP = -1;

   logic        clk;
   logic        rst_n;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_ack, if_err;
   logic [31:0] if_rdata;
   logic        d_req, d_we;
   logic [31:0] d_addr, d_wdata;
   logic        d_ack, d_err;
   logic [31:0] d_rdata;
   logic [31:0] mem_addr, mem_data_in;
   logic        mem_load_store;
   logic [1:0]  mem_op;
   logic [31:0] mem_data_out;
   logic        mem_done;
   logic        busy, owner_d;

   logic        model_done;
   logic        spur_done;
   assign mem_done = model_done | spur_done;

   mem_arbiter #(.TIMEOUT(T)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_err(if_err), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
      .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_load_store(mem_load_store),
      .mem_op(mem_op), .mem_data_out(mem_data_out), .mem_done(mem_done),
      .busy(busy), .owner_d(owner_d)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_pass   = 0;

   // Memory contents seen by the responder, and the reference model's own copy.
   logic [31:0] mem_arr [logic [31:0]];
   logic [31:0] ref_mem [logic [31:0]];
   int          mem_lat;

   bit          pend_if, pend_d, last_d;
   logic [31:0] exp_if_rd, exp_d_rd;
   bit          if_rd_ok, d_rd_ok;

   function automatic logic [31:0] dflt(input logic [31:0] a);
      return a ^ 32'h5A5A_0F0F;
   endfunction

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (mem_arr.exists(a)) return mem_arr[a];
      return dflt(a);
   endfunction

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      if (ref_mem.exists(a)) return ref_mem[a];
      return dflt(a);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Memory responder: one strobe -> optional completion after mem_lat WAIT cycles.
   initial begin : mem_model
      int          lat_now;
      logic [31:0] a;
      bit          st;
      model_done   = 1'b0;
      mem_data_out = 32'h0;
      forever begin
         @(negedge clk);
         if (mem_load_store === 1'b1) begin
            lat_now = mem_lat;
            a       = mem_addr;
            st      = (mem_op == 2'b01);
            if (st) mem_arr[a] = mem_data_in;
            if (lat_now >= 0) begin
               @(posedge clk); #1;
               repeat (lat_now) begin
                  @(posedge clk); #1;
               end
               model_done   = 1'b1;
               mem_data_out = st ? $urandom : mem_rd(a);
               @(posedge clk); #1;
               model_done   = 1'b0;
               mem_data_out = $urandom;
            end
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic new_if();
      if_addr = 32'($urandom_range(0, 15)) << 2;
      pend_if = 1'b1;
   endtask

   task automatic new_d(input bit we);
      d_addr  = 32'($urandom_range(0, 15)) << 2;
      d_wdata = $urandom;
      d_we    = we;
      pend_d  = 1'b1;
   endtask

   // Runs one grant/complete cycle, starting right after a rising edge with the arbiter idle.
   task automatic serve(input int lat, input string tag);
      bit          win_d, we, got, err;
      logic [31:0] a, wd, exp_rd;
      int          exp_c;
      if (pend_if && pend_d) begin
`ifdef MEM_ARB_RR_EN
         win_d = !last_d;
`else
         win_d = 1'b1;
`endif
      end else begin
         win_d = pend_d;
      end
      we    = win_d & d_we;
      a     = win_d ? d_addr : if_addr;
      wd    = d_wdata;
      err   = (lat < 0);
      exp_c = 3 + (err ? T - 1 : lat);
      mem_lat = lat;
      if_req  = pend_if;
      d_req   = pend_d;
      got     = 1'b0;
      for (int c = 0; c <= exp_c + 4 && !got; c++) begin
         @(negedge clk);
         chk({tag, ".strobe"}, 32'(mem_load_store), 32'(c == 1));
         chk({tag, ".busy"},   32'(busy),           32'(c != 0));
         if (c == 1) begin
            chk({tag, ".op"},   32'(mem_op), 32'({1'b0, we}));
            chk({tag, ".addr"}, mem_addr,    a);
            if (we) chk({tag, ".wdata"}, mem_data_in, wd);
         end
         if (if_ack === 1'b1 || d_ack === 1'b1) begin
            got = 1'b1;
            chk({tag, ".ack_cycle"}, 32'(c), 32'(exp_c));
            chk({tag, ".acks"},  32'({if_ack, d_ack}), 32'({!win_d, win_d}));
            chk({tag, ".errs"},  32'({if_err, d_err}), err ? 32'({!win_d, win_d}) : 32'd0);
            chk({tag, ".owner"}, 32'(owner_d), 32'(win_d));
            if (!err && !we) begin
               exp_rd = ref_rd(a);
               chk({tag, ".rdata"}, win_d ? d_rdata : if_rdata, exp_rd);
               if (win_d) begin exp_d_rd = exp_rd; d_rd_ok = 1'b1; end
               else begin exp_if_rd = exp_rd; if_rd_ok = 1'b1; end
            end else if (win_d) begin
               d_rd_ok = 1'b0;
            end else begin
               if_rd_ok = 1'b0;
            end
            if (win_d && if_rd_ok)  chk({tag, ".if_hold"}, if_rdata, exp_if_rd);
            if (!win_d && d_rd_ok)  chk({tag, ".d_hold"},  d_rdata,  exp_d_rd);
         end
      end
      if (!got) chk({tag, ".ack_seen"}, 32'd0, 32'd1);
      if (we) ref_mem[a] = wd;
      if (win_d) begin d_req = 1'b0; pend_d = 1'b0; end
      else begin if_req = 1'b0; pend_if = 1'b0; end
      last_d = win_d;
      @(posedge clk); #1;
   endtask

   initial begin : stim
      int lat, r;
      rst_n = 1'b0; if_req = 1'b0; if_addr = '0;
      d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
      spur_done = 1'b0; mem_lat = 0;
      pend_if = 1'b0; pend_d = 1'b0; last_d = 1'b0;
      exp_if_rd = '0; exp_d_rd = '0; if_rd_ok = 1'b1; d_rd_ok = 1'b1;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst.acks",   32'({if_ack, d_ack, if_err, d_err}), 32'd0);
      chk("rst.strobe", 32'(mem_load_store), 32'd0);
      chk("rst.busy",   32'(busy),    32'd0);
      chk("rst.owner",  32'(owner_d), 32'd0);
      chk("rst.op",     32'(mem_op),  32'd0);
      chk("rst.maddr",  mem_addr,     32'd0);
      chk("rst.mdin",   mem_data_in,  32'd0);
      chk("rst.ifrd",   if_rdata,     32'd0);
      chk("rst.drd",    d_rdata,      32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Fetch load returning a known word
      mem_arr[32'h10] = 32'hCAFE_0001;
      ref_mem[32'h10] = 32'hCAFE_0001;
      if_addr = 32'h10; pend_if = 1'b1;
      serve(0, "fetch");
      chk("fetch.word", if_rdata, 32'hCAFE_0001);

      // Data store
      d_addr = 32'h20; d_wdata = 32'h1234_5678; d_we = 1'b1; pend_d = 1'b1;
      serve(0, "store");

      // Data load of the stored word
      d_we = 1'b0; pend_d = 1'b1;
      serve(1, "dload");
      chk("dload.word", d_rdata, 32'h1234_5678);

      // Contention: both ports held across four grants
      new_if(); new_d(1'b0);
      for (int k = 0; k < 4; k++) begin
         serve(0, $sformatf("contend%0d", k));
         if (last_d) new_d(1'b0);
         else new_if();
      end
      while (pend_if || pend_d) serve(0, "drain");

      // Timeout and timeout/completion coincidence
      new_if();
      serve(NO_RESP, "timeout");
      new_d(1'b0);
      serve(T - 1, "coincide");

      // Spurious completion while idle
      spur_done = 1'b1;
      @(negedge clk);
      chk("spur.busy", 32'(busy), 32'd0);
      chk("spur.acks", 32'({if_ack, d_ack}), 32'd0);
      @(posedge clk); #1;
      spur_done = 1'b0;
      @(negedge clk);
      chk("spur.busy2", 32'(busy), 32'd0);
      chk("spur.acks2", 32'({if_ack, d_ack}), 32'd0);
      @(posedge clk); #1;

      // Reset in the middle of WAIT
      new_if();
      mem_lat = NO_RESP;
      if_req  = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("midrst.busy",   32'(busy), 32'd0);
      chk("midrst.acks",   32'({if_ack, d_ack, if_err, d_err}), 32'd0);
      chk("midrst.strobe", 32'(mem_load_store), 32'd0);
      chk("midrst.owner",  32'(owner_d), 32'd0);
      if_req = 1'b0; pend_if = 1'b0; last_d = 1'b0;
      exp_if_rd = '0; exp_d_rd = '0; if_rd_ok = 1'b1; d_rd_ok = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      new_if();
      serve(0, "after_rst");

      // Randomized traffic
      for (int i = 0; i < 40; i++) begin
         if (!pend_if && $urandom_range(0, 1) == 1) new_if();
         if (!pend_d && $urandom_range(0, 1) == 1) new_d(1'($urandom_range(0, 1)));
         if (!pend_if && !pend_d) new_if();
         r = $urandom_range(0, 9);
         if (r < 5)       lat = 0;
         else if (r < 7)  lat = $urandom_range(1, 3);
         else if (r == 7) lat = T - 1;
         else if (r == 8) lat = NO_RESP;
         else             lat = T - 2;
         serve(lat, $sformatf("rnd%0d", i));
      end
      while (pend_if || pend_d) serve(0, "rnd_drain");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, giving the maximum number of WAIT cycles before a transaction is aborted.
REQ-002 SHALL have port clk, input, 1, the single clock; every register updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-004 SHALL have port if_req, input, 1, instruction-fetch read request.
REQ-005 SHALL have port if_addr, input, 32, fetch address.
REQ-006 SHALL have ports if_ack, output, 1, and if_err, output, 1: fetch completion pulse and fetch error pulse.
REQ-007 SHALL have port if_rdata, output, 32, fetch read data.
REQ-008 SHALL have port d_req, input, 1, data load/store request.
REQ-009 SHALL have port d_we, input, 1: 1 = store, 0 = load.
REQ-010 SHALL have ports d_addr, input, 32, and d_wdata, input, 32: data address and store data.
REQ-011 SHALL have ports d_ack, output, 1, d_err, output, 1, and d_rdata, output, 32: data completion pulse, error pulse and load data.
REQ-012 SHALL have ports mem_addr, output, 32, and mem_data_in, output, 32: memory address and memory write data.
REQ-013 SHALL have ports mem_load_store, output, 1, and mem_op, output, 2: memory strobe and operation, 00 = load, 01 = store.
REQ-014 SHALL have ports mem_data_out, input, 32, and mem_done, input, 1: memory read data and memory completion flag.
REQ-015 SHALL have ports busy, output, 1, high whenever state != IDLE, and owner_d, output, 1, 1 when the current or last grant is the data port.

Function
REQ-016 SHALL implement a four-state FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
REQ-017 IDLE: SHALL sample if_req and d_req; on any request it grants one port, latches that port's addr, wdata and op into internal registers, and enters ISSUE.
REQ-018 ISSUE: SHALL assert mem_load_store for exactly one cycle with mem_addr, mem_data_in and mem_op driven from the latched values, then enter WAIT.
REQ-019 WAIT: SHALL keep mem_load_store = 0 and mem_addr/mem_data_in/mem_op stable; on mem_done = 1 it captures mem_data_out and enters RESP.
REQ-020 RESP: SHALL pulse the granted port's ack for one cycle with rdata valid in the same cycle, then return to IDLE.
REQ-021 rdata SHALL hold its value until the next completion on the same port; for a store, d_rdata is unspecified and d_ack still pulses.
REQ-022 Timing with the single-cycle memory: request seen at IDLE in cycle N -> ISSUE in N+1 -> mem_done in N+2 -> ack in N+3.
REQ-023 Back-to-back grants SHALL occur no sooner than the cycle after RESP.
REQ-024 Requester handshake: req, addr, wdata and we SHALL stay stable until ack; the requester drops req in the ack cycle; the arbiter never samples req outside IDLE.
REQ-025 Timeout: a counter SHALL increment each WAIT cycle; when it reaches TIMEOUT-1 without mem_done, the FSM enters RESP and pulses ack together with err; the counter clears on entering WAIT.
REQ-026 If mem_done and the timeout coincide, mem_done SHALL win: err = 0 and data is captured.
REQ-027 A mem_done that arrives outside WAIT SHALL be ignored.
REQ-028 if_ack, d_ack, if_err and d_err SHALL never be asserted simultaneously for both ports.

Reset
REQ-029 When rst_n = 0 at a clock edge, the block SHALL enter IDLE; all ack, err, mem_load_store, busy and owner_d = 0; mem_op = 00; mem_addr, mem_data_in, if_rdata, d_rdata = 0; timeout counter = 0; last-grant = fetch.
REQ-030 Reset mid-transaction SHALL abandon the transaction with no ack issued; a store already strobed may still complete in memory.

Configuration
REQ-031 With MEM_ARB_RR_EN defined, contention in IDLE SHALL be resolved round-robin: the grant goes to the port not granted last, and the last-grant register updates on every grant.
REQ-032 Without MEM_ARB_RR_EN, the data port SHALL always win contention (fixed priority), and the last-grant register is still maintained for owner_d.

Verification
REQ-033 Reset, then if_req=1, if_addr=0x10 with mem_data_out=0xCAFE0001 returned -> mem_load_store high only in cycle 1, mem_op=00, if_ack in cycle 3, if_rdata=0xCAFE0001.
REQ-034 d_req=1, d_we=1, d_addr=0x20, d_wdata=0x12345678 -> mem_op=01, mem_data_in=0x12345678 during ISSUE, d_ack after 3 cycles, if_ack stays 0.
REQ-035 if_req and d_req both held for 4 transactions with MEM_ARB_RR_EN defined -> grant order D, IF, D, IF; without the macro -> D, D, D, D while d_req is held.
REQ-036 mem_done tied 0, TIMEOUT=16 -> ack with err=1 exactly 16 cycles after entering WAIT, then return to IDLE.
REQ-037 rst_n=0 asserted during WAIT -> next cycle IDLE, busy=0, no ack; a new request then completes normally.
REQ-038 Spurious mem_done pulse while IDLE -> no state change, no ack.
